// File: rtl/vga_fb_writer_if.sv
// Pixel-stream and frame-buffer write bus for vga_fb_writer.
// The master side drives commands and pixels; the slave side is the writer block.
interface vga_fb_writer_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              start;
  logic              clr;
  logic              fill;
  logic              pix_valid;
  logic              pix_data;
  logic              pix_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic              busy;
  logic              frame_done;

  modport master (
    output start, clr, fill, pix_valid, pix_data,
    input  pix_ready, ram_addr, ram_wdata, ram_we, busy, frame_done
  );

  modport slave (
    input  start, clr, fill, pix_valid, pix_data,
    output pix_ready, ram_addr, ram_wdata, ram_we, busy, frame_done
  );
endinterface

// File: rtl/vga_fb_writer.sv
// Packs a raster-order monochrome pixel stream into an 8-pixels-per-byte frame
// buffer (pixel 0 in bit 0), or fills the whole buffer with a constant.
module vga_fb_writer #(
  parameter int unsigned H_PIX  = 128,
  parameter int unsigned V_PIX  = 128,
  parameter int unsigned ADDR_W = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_fb_writer_if.slave bus
);

  localparam int unsigned       BYTES     = H_PIX * V_PIX / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CLEAR,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        bit_cnt;
  logic [7:0]        pack;
  logic [7:0]        pack_next;
  logic              fill_q;
  logic [7:0]        wdata;
  logic              we;
  logic              ready;
  logic              busy_q;
  logic              done_q;

  assign bus.ram_addr   = addr;
  assign bus.ram_wdata  = wdata;
  assign bus.ram_we     = we;
  assign bus.pix_ready  = ready;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

  always_comb begin
    pack_next          = pack;
    pack_next[bit_cnt] = bus.pix_data;
  end

  // Outputs are set one cycle ahead, on the transition into the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      bit_cnt <= '0;
      pack    <= '0;
      fill_q  <= 1'b0;
      wdata   <= '0;
      we      <= 1'b0;
      ready   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.clr) begin
            state  <= CLEAR;
            addr   <= '0;
            fill_q <= bus.fill;
            wdata  <= {8{bus.fill}};
            we     <= 1'b1;
            busy_q <= 1'b1;
          end else if (bus.start) begin
            state   <= RECV;
            addr    <= '0;
            bit_cnt <= '0;
            ready   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        RECV: begin
          if (bus.pix_valid && ready) begin
            pack    <= pack_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= WRITE;
              ready <= 1'b0;
              we    <= 1'b1;
              wdata <= pack_next;
            end
          end
        end

        WRITE: begin
          we <= 1'b0;
          if (addr == LAST_ADDR) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            addr  <= addr + ADDR_ONE;
            state <= RECV;
            ready <= 1'b1;
          end
        end

        CLEAR: begin
          wdata <= {8{fill_q}};
          if (addr == LAST_ADDR) begin
            state  <= DONE;
            we     <= 1'b0;
            done_q <= 1'b1;
          end else begin
            addr <= addr + ADDR_ONE;
          end
        end

        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          we     <= 1'b0;
          ready  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_writer.sv
// Scoreboard bench for vga_fb_writer: expected RAM writes are queued as stimulus
// is issued and matched against every ram_we cycle.
module tb_vga_fb_writer;

  localparam int unsigned ADDR_W = 11;
  localparam int          BYTES  = 2048;
  localparam int          PIXELS = BYTES * 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vga_fb_writer_if #(.ADDR_W(ADDR_W)) bus ();

  vga_fb_writer #(.H_PIX(128), .V_PIX(128), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  int done_cnt = 0;
  int acc = 0;
  int first_acc_cyc = 0;
  bit stream_mode = 1'b0;
  int pix_mode = 0;
  logic [7:0] pat = 8'h00;
  logic [18:0] expq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [18:0] e;
    if (bus.frame_done) done_cnt++;
    if (bus.ram_we) begin
      if (expq.size() == 0) begin
        check("unexp_we", 32'(bus.ram_addr), 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        check("wr_addr", 32'(bus.ram_addr), 32'(e[18:8]));
        check("wr_data", 32'(bus.ram_wdata), 32'(e[7:0]));
      end
      if (stream_mode) check("acc_before_wr", 32'(acc), 32'(8 * (wr_cnt + 1)));
      if (wr_cnt == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      wr_cnt++;
    end
  end

  function automatic logic pix_of(input int i);
    if (pix_mode == 0) return pat[i & 7];
    return (i == 3 * 128 + 9);
  endfunction

  task automatic stream(input int n, input bit rnd);
    int i = 0;
    int guard = 0;
    logic v;
    acc = 0;
    while (i < n && guard < n * 4 + 1000) begin
      @(negedge clk);
      guard++;
      v = rnd ? ($urandom_range(3) != 0) : 1'b1;
      bus.pix_valid = v;
      bus.pix_data  = pix_of(i);
      if (v && bus.pix_ready) begin
        if (i == 0) first_acc_cyc = cyc;
        i++;
        acc = i;
      end
    end
    check("stream_to", 32'(i), 32'(n));
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.pix_data  = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n = 0;
    while (!bus.frame_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(bus.frame_done), 32'd1);
  endtask

  task automatic pulse(input logic s, input logic c, input logic f);
    @(negedge clk);
    bus.start = s;
    bus.clr   = c;
    bus.fill  = f;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    bus.fill  = 1'b0;
  endtask

  task automatic push_frame(input bit one_pixel, input logic [7:0] val);
    for (int a = 0; a < BYTES; a++)
      expq.push_back({11'(a), one_pixel ? ((a == 49) ? 8'h02 : 8'h00) : val});
  endtask

  initial begin
    int d;
    bus.start = 1'b0; bus.clr = 1'b0; bus.fill = 1'b0;
    bus.pix_valid = 1'b0; bus.pix_data = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_we", 32'(bus.ram_we), 0);
    check("rst_addr", 32'(bus.ram_addr), 0);
    check("rst_wdata", 32'(bus.ram_wdata), 0);
    check("rst_ready", 32'(bus.pix_ready), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.frame_done), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_wr", 32'(wr_cnt), 0);

    // Clear with fill=1
    wr_cnt = 0; stream_mode = 1'b0;
    push_frame(1'b0, 8'hFF);
    pulse(1'b0, 1'b1, 1'b1);
    wait_done(BYTES + 20, "clr1");
    d = cyc;
    check("clr1_wr_cnt", 32'(wr_cnt), 32'(BYTES));
    check("clr1_consec", 32'(last_wr_cyc - first_wr_cyc), 32'(BYTES - 1));
    check("clr1_done_lat", 32'(d - last_wr_cyc), 1);
    check("clr1_q_empty", 32'(expq.size()), 0);
    @(negedge clk);
    check("clr1_busy_after", 32'(bus.busy), 0);
    check("clr1_done_pulse", 32'(bus.frame_done), 0);

    // Single byte 1,0,0,0,0,0,0,1 -> 8'h81 at address 0
    wr_cnt = 0; stream_mode = 1'b1; pix_mode = 0; pat = 8'h81;
    expq.push_back({11'd0, 8'h81});
    pulse(1'b1, 1'b0, 1'b0);
    stream(8, 1'b0);
    check("b81_we", 32'(bus.ram_we), 1);
    check("b81_ready_lo", 32'(bus.pix_ready), 0);
    @(negedge clk);
    check("b81_ready_hi", 32'(bus.pix_ready), 1);
    check("b81_q_empty", 32'(expq.size()), 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full frame, back-to-back pixels, single set pixel at (9,3)
    wr_cnt = 0; pix_mode = 1;
    push_frame(1'b1, 8'h00);
    pulse(1'b1, 1'b0, 1'b0);
    stream(PIXELS, 1'b0);
    wait_done(20, "full");
    check("full_cycles", 32'(cyc - first_acc_cyc), 32'(BYTES * 9));
    check("full_wr_cnt", 32'(wr_cnt), 32'(BYTES));
    check("full_q_empty", 32'(expq.size()), 0);
    @(negedge clk);
    check("full_busy_after", 32'(bus.busy), 0);

    // Same frame with random pix_valid gaps
    wr_cnt = 0;
    push_frame(1'b1, 8'h00);
    pulse(1'b1, 1'b0, 1'b0);
    stream(PIXELS, 1'b1);
    wait_done(20, "rnd");
    check("rnd_wr_cnt", 32'(wr_cnt), 32'(BYTES));
    check("rnd_q_empty", 32'(expq.size()), 0);
    @(negedge clk);

    // start+clr together: clear wins, later start during clear ignored
    wr_cnt = 0; stream_mode = 1'b0;
    push_frame(1'b0, 8'h00);
    pulse(1'b1, 1'b1, 1'b0);
    check("both_ready", 32'(bus.pix_ready), 0);
    repeat (100) @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0);
    check("both_ready_mid", 32'(bus.pix_ready), 0);
    wait_done(BYTES + 20, "both");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("both_no_recv", 32'({bus.pix_ready, bus.busy}), 0);
    end
    check("both_wr_cnt", 32'(wr_cnt), 32'(BYTES));
    check("both_q_empty", 32'(expq.size()), 0);

    // Reset in the middle of a clear at address 1000
    wr_cnt = 0;
    for (int a = 0; a <= 1000; a++) expq.push_back({11'(a), 8'hFF});
    pulse(1'b0, 1'b1, 1'b1);
    d = 0;
    while (!(bus.ram_we && bus.ram_addr == 11'd1000) && d < BYTES) begin
      @(negedge clk);
      d++;
    end
    #1 rst_n = 1'b0;
    #1;
    check("arst_we", 32'(bus.ram_we), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_q_empty", 32'(expq.size()), 0);
    check("arst_wr_cnt", 32'(wr_cnt), 1001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("arst_idle", 32'(wr_cnt), 1001);
    wr_cnt = 0; stream_mode = 1'b1; pix_mode = 0; pat = 8'hA5;
    expq.push_back({11'd0, 8'hA5});
    pulse(1'b1, 1'b0, 1'b0);
    stream(8, 1'b0);
    @(negedge clk);
    check("arst_restart_wr", 32'(wr_cnt), 1);
    check("arst_restart_q", 32'(expq.size()), 0);
    check("done_total", 32'(done_cnt), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_writer.md
VGA_FB_WRITER -- requirements
Module: vga_fb_writer

Interface
REQ-001 Parameter H_PIX, 128, active pixels per line; SHALL be a multiple of 8.
REQ-002 Parameter V_PIX, 128, active lines per frame.
REQ-003 Parameter ADDR_W, 11, RAM address width; SHALL satisfy 2^ADDR_W >= H_PIX*V_PIX/8.
REQ-004 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a pixel-stream frame load.
REQ-007 clr  in  1  one-cycle pulse that begins a full-buffer fill.
REQ-008 fill  in  1  fill value for clr; sampled in the same cycle as clr.
REQ-009 pix_valid  in  1  pixel-stream valid.
REQ-010 pix_data  in  1  monochrome pixel, raster order, x fastest.
REQ-011 pix_ready  out  1  pixel-stream ready.
REQ-012 ram_addr  out  ADDR_W  frame-buffer byte address.
REQ-013 ram_wdata  out  8  frame-buffer write byte.
REQ-014 ram_we  out  1  write strobe; one byte is written per high cycle.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 frame_done  out  1  one-cycle pulse at the end of a load or a fill.

Function
REQ-017 The block SHALL use the states IDLE, RECV, WRITE, CLEAR and DONE; all outputs SHALL be registered.
REQ-018 Memory map: pixel (x,y) SHALL be stored at address y*(H_PIX/8) + x/8, bit x mod 8 (pixel 0 of each byte in bit 0), so the display reader's rom_data[x&7] lookup returns that pixel.
REQ-019 IDLE: pix_ready=0, ram_we=0, busy=0.
REQ-020 IDLE transitions:
  - clr -> CLEAR, with address counter=0 and the fill value latched.
  - start (without clr) -> RECV, with address=0 and bit count=0.
  - clr and start in the same cycle -> clr wins; start is dropped.
REQ-021 RECV: pix_ready=1; a pixel is accepted on each cycle where pix_valid && pix_ready; the accepted pixel SHALL be stored at bit position = bit count, and the bit count SHALL increment mod 8.
REQ-022 Acceptance of the 8th pixel of a byte SHALL move the block to WRITE; pix_ready SHALL be 0 in the following cycle.
REQ-023 WRITE lasts exactly one cycle:
  - ram_we=1, ram_wdata=packed byte, ram_addr=current byte address.
  - Next state is DONE if the address equals H_PIX*V_PIX/8-1; otherwise the address increments and the next state is RECV.
  - Sustained throughput SHALL be 8 pixels per 9 cycles.
REQ-024 pix_valid low in RECV SHALL stall the block with no timeout; partial-byte contents SHALL be held.
REQ-025 CLEAR: ram_we=1 every cycle, ram_wdata={8{latched fill}}, ram_addr counts from 0 up to H_PIX*V_PIX/8-1, one address per cycle, then -> DONE; pix_ready=0 throughout.
REQ-026 DONE: frame_done=1 for one cycle, ram_we=0, then -> IDLE.
REQ-027 start and clr SHALL be ignored while busy=1.
REQ-028 ram_we SHALL never be high outside WRITE and CLEAR.
REQ-029 Address arithmetic SHALL be ADDR_W bits wide and SHALL never wrap past the last frame byte.

Reset
REQ-030 While rst_n=0, regardless of state:
  - ram_we=0, ram_addr=0, ram_wdata=0
  - pix_ready=0, busy=0, frame_done=0
  - bit count=0, state=IDLE
REQ-031 A reset during RECV, WRITE or CLEAR SHALL abandon the operation with no further RAM writes; a partially written buffer is acceptable.
REQ-032 After reset release, the block SHALL require a new start or clr pulse before any activity.

Verification
REQ-033 clr with fill=1 -> exactly 2048 consecutive ram_we cycles, addresses 0..2047, wdata=8'hFF, then a single frame_done pulse 1 cycle after the last write, busy low the cycle after.
REQ-034 start, then pixels 1,0,0,0,0,0,0,1 with pix_valid held high -> ram_we at addr 0 with wdata=8'h81, and pix_ready low for exactly that one cycle.
REQ-035 Full frame where pixel=1 only at (x=9,y=3) -> byte 49 = 8'h02, all other 2047 bytes = 8'h00; frame_done after write of addr 2047; total cycles from first accept = 2048*9.
REQ-036 pix_valid toggled randomly in RECV -> identical RAM image to the back-to-back case; no write until 8 pixels are accepted.
REQ-037 start and clr in the same IDLE cycle -> CLEAR entered; pix_ready stays 0; start pulse during CLEAR ignored (no RECV after DONE).
REQ-038 rst_n asserted at CLEAR address 1000 -> ram_we low immediately (asynchronously), busy=0; a following start -> first write at addr 0.
